// File: rtl/i2c_slave_core.sv
// I2C target bit engine: filtered SCL/SDA, START/STOP detect, 7-bit address match, byte receive/transmit with ACK.
// Latency ~FILTER_LEN+3 clk from pad to action; no backpressure, tx_data is sampled on the tx_req cycle.
// Build option I2C_SLAVE_GCALL_EN: also ACK the general-call address 8'h00 as a write.
module i2c_slave_core #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50,
    parameter int         FILTER_LEN = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_first,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       addressed,
    output logic       rw,
    output logic       busy
);

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_ADDR       = 3'd1;
    localparam logic [2:0] ST_ADDR_ACK   = 3'd2;
    localparam logic [2:0] ST_RX_BYTE    = 3'd3;
    localparam logic [2:0] ST_RX_ACK     = 3'd4;
    localparam logic [2:0] ST_TX_BYTE    = 3'd5;
    localparam logic [2:0] ST_TX_ACK_CHK = 3'd6;
    localparam logic [2:0] ST_WAIT_STOP  = 3'd7;

    logic [1:0]            scl_sync, sda_sync;
    logic [FILTER_LEN-1:0] scl_hist, sda_hist;
    logic                  scl_f, sda_f, scl_prev, sda_prev;
    logic                  scl_rise, scl_fall, sda_rise, sda_fall;
    logic                  start_det, stop_det;

    logic [2:0] state;
    logic [2:0] bit_cnt;
    logic [7:0] shift_reg;
    logic [7:0] tx_shift;
    logic [7:0] tx_buf;
    logic       byte_done;
    logic       first_pending;
    logic       ack_ok;
    logic       addr_hit, gcall_hit;

    // Filtered level only moves once the whole sample history agrees.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_hist <= '1;
            sda_hist <= '1;
            scl_f    <= 1'b1;
            sda_f    <= 1'b1;
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], scl_in};
            sda_sync <= {sda_sync[0], sda_in};
            scl_hist <= {scl_hist[FILTER_LEN-2:0], scl_sync[1]};
            sda_hist <= {sda_hist[FILTER_LEN-2:0], sda_sync[1]};
            if (&scl_hist)       scl_f <= 1'b1;
            else if (~|scl_hist) scl_f <= 1'b0;
            if (&sda_hist)       sda_f <= 1'b1;
            else if (~|sda_hist) sda_f <= 1'b0;
            scl_prev <= scl_f;
            sda_prev <= sda_f;
        end
    end

    assign scl_rise  = scl_f & ~scl_prev;
    assign scl_fall  = ~scl_f & scl_prev;
    assign sda_rise  = sda_f & ~sda_prev;
    assign sda_fall  = ~sda_f & sda_prev;
    assign start_det = sda_fall & scl_f;
    assign stop_det  = sda_rise & scl_f;

    assign addr_hit = (shift_reg[7:1] == SLAVE_ADDR);
`ifdef I2C_SLAVE_GCALL_EN
    assign gcall_hit = (shift_reg == 8'h00);
`else
    assign gcall_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= ST_IDLE;
            bit_cnt       <= 3'd0;
            shift_reg     <= 8'h00;
            tx_shift      <= 8'h00;
            tx_buf        <= 8'h00;
            byte_done     <= 1'b0;
            first_pending <= 1'b0;
            ack_ok        <= 1'b0;
            sda_oe        <= 1'b0;
            rx_data       <= 8'h00;
            rx_valid      <= 1'b0;
            rx_first      <= 1'b0;
            tx_req        <= 1'b0;
            addressed     <= 1'b0;
            rw            <= 1'b0;
            busy          <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            tx_req   <= 1'b0;
            if (tx_req) tx_buf <= tx_data;

            if (start_det) begin
                state         <= ST_ADDR;
                bit_cnt       <= 3'd0;
                byte_done     <= 1'b0;
                ack_ok        <= 1'b0;
                sda_oe        <= 1'b0;
                addressed     <= 1'b0;
                busy          <= 1'b1;
                rx_first      <= 1'b0;
                first_pending <= 1'b1;
            end else if (stop_det) begin
                state     <= ST_IDLE;
                sda_oe    <= 1'b0;
                addressed <= 1'b0;
                busy      <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        sda_oe <= 1'b0;
                    end
                    // Bits are counted on rise, so the SCL fall that completes START is ignored.
                    ST_ADDR: begin
                        if (scl_rise) begin
                            shift_reg <= {shift_reg[6:0], sda_f};
                            bit_cnt   <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) byte_done <= 1'b1;
                        end else if (scl_fall && byte_done) begin
                            byte_done <= 1'b0;
                            if (addr_hit) begin
                                rw     <= shift_reg[0];
                                sda_oe <= 1'b1;
                                tx_req <= shift_reg[0];
                                state  <= ST_ADDR_ACK;
                            end else if (gcall_hit) begin
                                rw     <= 1'b0;
                                sda_oe <= 1'b1;
                                state  <= ST_ADDR_ACK;
                            end else begin
                                sda_oe <= 1'b0;
                                state  <= ST_WAIT_STOP;
                            end
                        end
                    end
                    ST_ADDR_ACK: begin
                        if (scl_fall) begin
                            addressed <= 1'b1;
                            bit_cnt   <= 3'd0;
                            if (rw) begin
                                tx_shift <= tx_buf;
                                sda_oe   <= ~tx_buf[7];
                                state    <= ST_TX_BYTE;
                            end else begin
                                sda_oe <= 1'b0;
                                state  <= ST_RX_BYTE;
                            end
                        end
                    end
                    ST_RX_BYTE: begin
                        if (scl_rise) begin
                            shift_reg <= {shift_reg[6:0], sda_f};
                            bit_cnt   <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) byte_done <= 1'b1;
                        end else if (scl_fall && byte_done) begin
                            byte_done     <= 1'b0;
                            rx_data       <= shift_reg;
                            rx_valid      <= 1'b1;
                            rx_first      <= first_pending;
                            first_pending <= 1'b0;
                            sda_oe        <= 1'b1;
                            state         <= ST_RX_ACK;
                        end
                    end
                    ST_RX_ACK: begin
                        if (scl_fall) begin
                            sda_oe <= 1'b0;
                            state  <= ST_RX_BYTE;
                        end
                    end
                    // Prefetch the next byte while the last bit of this one is on the wire.
                    ST_TX_BYTE: begin
                        if (scl_fall) begin
                            if (bit_cnt == 3'd7) begin
                                bit_cnt <= 3'd0;
                                sda_oe  <= 1'b0;
                                ack_ok  <= 1'b0;
                                state   <= ST_TX_ACK_CHK;
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                                sda_oe  <= ~tx_shift[3'd6 - bit_cnt];
                                if (bit_cnt == 3'd6) tx_req <= 1'b1;
                            end
                        end
                    end
                    ST_TX_ACK_CHK: begin
                        if (scl_rise) begin
                            if (sda_f) state <= ST_WAIT_STOP;
                            else       ack_ok <= 1'b1;
                        end else if (scl_fall && ack_ok) begin
                            ack_ok   <= 1'b0;
                            tx_shift <= tx_buf;
                            sda_oe   <= ~tx_buf[7];
                            state    <= ST_TX_BYTE;
                        end
                    end
                    ST_WAIT_STOP: begin
                        sda_oe <= 1'b0;
                    end
                    default: begin
                        state  <= ST_IDLE;
                        sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_core.sv
// Directed bench for i2c_slave_core: bit-banged I2C master on a wired-AND SDA line.
module tb_i2c_slave_core;

    localparam int Q = 10;
`ifdef I2C_SLAVE_GCALL_EN
    localparam bit GCALL = 1'b1;
`else
    localparam bit GCALL = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       m_scl, m_sda;
    logic       sda_bus;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid, rx_first;
    logic [7:0] tx_data;
    logic       tx_req, addressed, rw, busy;

    int checks = 0;
    int failures = 0;

    logic [7:0] rx_log  [64];
    logic       rxf_log [64];
    int         rx_cnt = 0;
    int         txreq_cnt = 0;
    bit         both_seen = 1'b0;

    always #5 clk = ~clk;

    assign sda_bus = m_sda & ~sda_oe;

    i2c_slave_core #(.SLAVE_ADDR(7'h50), .FILTER_LEN(3)) dut (
        .clk(clk), .reset(reset), .scl_in(m_scl), .sda_in(sda_bus), .sda_oe(sda_oe),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_first(rx_first), .tx_data(tx_data),
        .tx_req(tx_req), .addressed(addressed), .rw(rw), .busy(busy)
    );

    always @(negedge clk) begin
        if (rx_valid && rx_cnt < 64) begin
            rx_log[rx_cnt]  = rx_data;
            rxf_log[rx_cnt] = rx_first;
            rx_cnt++;
        end
        if (tx_req) txreq_cnt++;
        if (rx_valid && tx_req) both_seen = 1'b1;
    end

    task automatic wq(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; wq(Q);
        m_scl = 1'b1; wq(Q);
        m_sda = 1'b0; wq(Q);
        m_scl = 1'b0; wq(Q);
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; wq(Q);
        m_scl = 1'b1; wq(Q);
        m_sda = 1'b1; wq(Q);
    endtask

    // glitch_bit >= 0 injects a one-clock SCL spike in that bit's low phase.
    task automatic write_byte(input logic [7:0] b, input int glitch_bit, output logic ack);
        for (int i = 7; i >= 0; i--) begin
            m_sda = b[i];
            if (i == glitch_bit) begin
                wq(Q/2);
                m_scl = 1'b1; wq(1);
                m_scl = 1'b0; wq(Q - Q/2 - 1);
            end else begin
                wq(Q);
            end
            m_scl = 1'b1; wq(2*Q);
            m_scl = 1'b0; wq(Q);
        end
        m_sda = 1'b1; wq(Q);
        m_scl = 1'b1; wq(Q);
        ack = ~sda_bus; wq(Q);
        m_scl = 1'b0; wq(Q);
    endtask

    task automatic read_bits(input int n, output logic [7:0] b);
        b = 8'h00;
        m_sda = 1'b1;
        for (int i = 0; i < n; i++) begin
            wq(Q);
            m_scl = 1'b1; wq(Q);
            b = {b[6:0], sda_bus}; wq(Q);
            m_scl = 1'b0; wq(Q);
        end
    endtask

    task automatic read_byte(input logic master_ack, output logic [7:0] b);
        read_bits(8, b);
        m_sda = ~master_ack; wq(Q);
        m_scl = 1'b1; wq(2*Q);
        m_scl = 1'b0; wq(Q);
        m_sda = 1'b1;
    endtask

    initial begin
        logic       ack;
        logic [7:0] b;
        int         rx_base, tx_base;

        m_scl = 1'b1; m_sda = 1'b1; tx_data = 8'h00;
        reset = 1'b0;
        wq(5);
        reset = 1'b1;
        wq(10);
        chk("rst_outputs", {sda_oe, rx_valid, rx_first, tx_req, addressed, rw, busy}, 7'b0);
        chk("rst_rx_data", rx_data, 8'h00);

        // Write 0x12, 0x34
        rx_base = rx_cnt;
        i2c_start();
        chk("w_busy", busy, 1'b1);
        write_byte(8'hA0, -1, ack); chk("w_addr_ack", ack, 1'b1);
        chk("w_addressed", addressed, 1'b1);
        chk("w_rw", rw, 1'b0);
        write_byte(8'h12, -1, ack); chk("w_d0_ack", ack, 1'b1);
        write_byte(8'h34, -1, ack); chk("w_d1_ack", ack, 1'b1);
        i2c_stop();
        chk("w_rx_count", rx_cnt - rx_base, 2);
        chk("w_rx0", {rx_log[rx_base], rxf_log[rx_base]}, {8'h12, 1'b1});
        chk("w_rx1", {rx_log[rx_base+1], rxf_log[rx_base+1]}, {8'h34, 1'b0});
        chk("w_stop_busy", busy, 1'b0);
        chk("w_stop_addressed", addressed, 1'b0);

        // Wrong address: NACK, then ignore data until STOP
        rx_base = rx_cnt;
        i2c_start();
        write_byte(8'hA2, -1, ack); chk("na_addr_ack", ack, 1'b0);
        chk("na_addressed", addressed, 1'b0);
        write_byte(8'h55, -1, ack); chk("na_data_ack", ack, 1'b0);
        chk("na_busy", busy, 1'b1);
        chk("na_rx_count", rx_cnt - rx_base, 0);
        i2c_stop();
        chk("na_stop_busy", busy, 1'b0);

        // Read 0xC5 (ACK) then 0x3A (NACK)
        tx_base = txreq_cnt;
        tx_data = 8'hC5;
        i2c_start();
        write_byte(8'hA1, -1, ack); chk("r_addr_ack", ack, 1'b1);
        chk("r_rw", rw, 1'b1);
        tx_data = 8'h3A;
        read_byte(1'b1, b); chk("r_byte0", b, 8'hC5);
        chk("r_txreq_count", txreq_cnt - tx_base, 2);
        read_byte(1'b0, b); chk("r_byte1", b, 8'h3A);
        chk("r_release_after_nack", sda_oe, 1'b0);
        i2c_stop();
        chk("r_stop_busy", busy, 1'b0);

        // Write 0x07, repeated START, read
        rx_base = rx_cnt;
        i2c_start();
        write_byte(8'hA0, -1, ack); chk("rs_addr_ack", ack, 1'b1);
        write_byte(8'h07, -1, ack); chk("rs_d_ack", ack, 1'b1);
        chk("rs_rw_before", rw, 1'b0);
        chk("rs_rx", {rx_log[rx_base], rxf_log[rx_base]}, {8'h07, 1'b1});
        tx_base = txreq_cnt;
        tx_data = 8'h5A;
        i2c_start();
        chk("rs_addressed_drop", {addressed, busy}, 2'b01);
        write_byte(8'hA1, -1, ack); chk("rs_raddr_ack", ack, 1'b1);
        chk("rs_rw_after", {rw, addressed}, 2'b11);
        chk("rs_txreq", txreq_cnt - tx_base, 1);
        read_byte(1'b0, b); chk("rs_rbyte", b, 8'h5A);
        i2c_stop();

        // SCL glitch inside a byte
        rx_base = rx_cnt;
        i2c_start();
        write_byte(8'hA0, -1, ack); chk("g_addr_ack", ack, 1'b1);
        write_byte(8'h96, 3, ack);  chk("g_d_ack", ack, 1'b1);
        i2c_stop();
        chk("g_rx_count", rx_cnt - rx_base, 1);
        chk("g_rx", rx_log[rx_base], 8'h96);

        // Reset while driving a 0 data bit
        tx_data = 8'hC5;
        i2c_start();
        write_byte(8'hA1, -1, ack); chk("rst_tx_addr_ack", ack, 1'b1);
        read_bits(2, b);
        chk("rst_tx_bits", b, 8'h03);
        chk("rst_tx_driving", sda_oe, 1'b1);
        #2 reset = 1'b0;
        #1 chk("rst_async_release", sda_oe, 1'b0);
        wq(3);
        chk("rst_busy", {busy, addressed}, 2'b00);
        m_scl = 1'b1; m_sda = 1'b1;
        wq(10);
        reset = 1'b1;
        wq(10);
        i2c_start();
        write_byte(8'hA0, -1, ack); chk("rst_recover_ack", ack, 1'b1);
        i2c_stop();

        // General call
        rx_base = rx_cnt;
        i2c_start();
        write_byte(8'h00, -1, ack); chk("gc_addr_ack", ack, GCALL);
        write_byte(8'h06, -1, ack); chk("gc_d_ack", ack, GCALL);
        i2c_stop();
        chk("gc_rx", (rx_cnt > rx_base) ? {23'd0, rx_log[rx_base], rxf_log[rx_base]} : 32'd0,
            GCALL ? {23'd0, 8'h06, 1'b1} : 32'd0);

        chk("no_rxvalid_txreq_overlap", both_seen, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/i2c_slave_core.md
Name: i2c_slave_core

Overview:
- I2C target (slave) bit engine; the responding end of the bus driven by the team's I2C master/SCL generator.
- Synchronises and filters SCL/SDA, detects START/STOP, and matches a 7-bit address.
- Receives write bytes and transmits read bytes with ACK/NACK.
- Presents a byte-wide valid/request interface to the local register file. Runs entirely on the system clock; SCL is only sampled as data.

Parameters:
- SLAVE_ADDR, 7'h50, 7-bit target address this block responds to.
- FILTER_LEN, 3, number of consecutive equal samples (2..7) required before a filtered SCL/SDA level changes.

Ports:
- clk  input  1  system clock (>= 20x SCL frequency)
- reset  input  1  asynchronous, active-low
- scl_in  input  1  raw SCL pad input
- sda_in  input  1  raw SDA pad input
- sda_oe  output  1  1 = pull SDA low (open-drain enable); 0 = release
- rx_data  output  8  last received data byte
- rx_valid  output  1  one-cycle pulse; rx_data valid
- rx_first  output  1  qualifies rx_valid: first data byte after address (register pointer)
- tx_data  input  8  byte to send; sampled on the cycle tx_req is high
- tx_req  output  1  one-cycle pulse requesting tx_data for the next read byte
- addressed  output  1  high from address ACK until STOP/repeated START
- rw  output  1  R/W bit of current transfer (1 = read)
- busy  output  1  high between START and STOP

Behaviour:
- Reset values: sda_oe=0, rx_data=0, rx_valid=0, rx_first=0, tx_req=0, addressed=0, rw=0, busy=0, state=IDLE.
- Input path:
  - 2-FF synchroniser per line, then a FILTER_LEN-sample majority-free debounce (all samples equal).
  - Filtered levels reset to 1.
  - Edge flags scl_rise, scl_fall, sda_rise, sda_fall are one-cycle pulses derived from the filtered levels.
- START = sda_fall while SCL high; STOP = sda_rise while SCL high. Both take priority over the bit FSM in any state.
- START (including repeated START): go to ADDR, bit count=0, sda_oe=0, addressed=0, busy=1, rx_first cleared for the next byte.
- STOP: go to IDLE, sda_oe=0, addressed=0, busy=0.
- Bit timing: SDA is sampled on scl_rise, MSB first; sda_oe changes only on scl_fall.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits. On the 8th scl_fall, if bits[7:1]==SLAVE_ADDR, latch rw=bit0, assert sda_oe, go to ADDR_ACK. Otherwise go to WAIT_STOP, releasing SDA.
  - ADDR_ACK: on scl_fall, set addressed=1. If rw=0, release SDA and go to RX_BYTE. If rw=1, drive the MSB of tx_data and go to TX_BYTE. tx_req pulses on the ADDR_ACK-entry cycle so tx_data is stable before that scl_fall.
  - RX_BYTE: on the 8th scl_fall, rx_data<=shift register, rx_valid pulse, rx_first=1 only for the first byte of the transfer, assert ACK (sda_oe=1), go to RX_ACK.
  - RX_ACK: on scl_fall, release SDA and return to RX_BYTE.
  - TX_BYTE:
    - sda_oe = ~current bit; advance to the next bit on scl_fall.
    - After 8 bits, release SDA and go to TX_ACK_CHK.
    - tx_req pulses on the cycle the 8th bit is shifted out, for the next byte.
  - TX_ACK_CHK: on scl_rise, sample the master ACK. SDA=0 (ACK): load the new byte and go to TX_BYTE on scl_fall. SDA=1 (NACK): go to WAIT_STOP.
  - WAIT_STOP: SDA released; only START/STOP exit.
- Bit counter is 3 bits and wraps 7->0 at each byte boundary.
- rx_valid and tx_req are never high in the same cycle.
- Reset asserted mid-transfer releases SDA immediately (asynchronous).

Optional Feature:
- Macro I2C_SLAVE_GCALL_EN.
- When defined: address byte 8'h00 (general call, rw=0) is also ACKed and treated as a write. rw=0, addressed=1, and rx_first=1 on the first data byte.
- When undefined: 8'h00 is NACKed and the FSM goes to WAIT_STOP.

Test Plan:
- START, address 8'hA0 (0x50, write), data 8'h12, 8'h34, STOP -> ACK on all three 9th clocks. rx_valid twice: rx_data=8'h12 with rx_first=1, then 8'h34 with rx_first=0. busy=0 after STOP.
- START, address 8'hA2 (0x51) -> SDA released on the 9th clock (NACK), no rx_valid, FSM in WAIT_STOP until STOP.
- START, 8'hA1 (read), tx_data=8'hC5 then 8'h3A, master ACKs the first and NACKs the second -> SDA carries C5 then 3A, tx_req pulses twice, SDA released after NACK.
- Write 8'h07 then repeated START with 8'hA1 read -> rw switches 0->1, addressed drops for the address phase then re-asserts, tx_req issued.
- 1-cycle glitch on SCL mid-byte with FILTER_LEN=3 -> no extra bit shifted, received byte unchanged. Reset pulled low during TX_BYTE -> sda_oe=0 the same cycle.
- With I2C_SLAVE_GCALL_EN: START, 8'h00, 8'h06, STOP -> ACK, rx_data=8'h06 with rx_first=1. Without it: NACK.
